// File: rtl/control_sequencer.sv
// control_sequencer: microcode sequencer driving the active-low bus strobes of the 8-bit CPU.
// Optional SEQ_SINGLE_STEP_EN adds i_step_req: advance and strobe only on requested cycles.
module control_sequencer #(
   parameter int SKIP_EMPTY_STEPS = 1,
   parameter int OPCODE_WIDTH     = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_instruction,
   input  logic       i_flag_carry,
   input  logic       i_flag_zero,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic       i_step_req,
`endif
   output logic       o_pc_read_n,
   output logic       o_pc_write_n,
   output logic       o_pc_inc_n,
   output logic       o_mar_write_n,
   output logic       o_ram_read_n,
   output logic       o_ram_write_n,
   output logic       o_ir_write_n,
   output logic       o_ir_read_n,
   output logic       o_a_read_n,
   output logic       o_a_write_n,
   output logic       o_b_write_n,
   output logic       o_alu_read_n,
   output logic       o_alu_sub,
   output logic       o_flags_write_n,
   output logic       o_out_write_n,
   output logic       o_halted,
   output logic [2:0] o_step
);
   logic [2:0] r_step, w_step_nxt, w_last;
   logic       r_halted, w_halted_nxt, w_adv, w_act;
   logic       w_t0, w_t1, w_t2, w_t3, w_t4, w_alu, w_mem, w_jmp;
   logic [OPCODE_WIDTH-1:0] w_op;
   // the operand nibble reaches the bus through the IR, never through this block
   logic       w_unused_operand;

   assign w_op             = i_instruction[7 -: OPCODE_WIDTH];
   assign w_unused_operand = ^i_instruction[3:0];
`ifdef SEQ_SINGLE_STEP_EN
   assign w_adv = i_step_req;
`else
   assign w_adv = 1'b1;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_step   <= 3'd0;
         r_halted <= 1'b0;
      end else begin
         r_step   <= w_step_nxt;
         r_halted <= w_halted_nxt;
      end
   end

   always_comb begin
      w_last       = (w_op == 4'h1 || w_op == 4'h4) ? 3'd3 : (w_op == 4'h2 || w_op == 4'h3) ? 3'd4 : 3'd2;
      w_step_nxt   = r_step;
      w_halted_nxt = r_halted;
      // the halting edge leaves the counter parked on T2
      if (!r_halted && w_adv) begin
         if (r_step == 3'd2 && w_op == 4'hF)
            w_halted_nxt = 1'b1;
         else
            w_step_nxt = ((SKIP_EMPTY_STEPS != 0 && r_step == w_last) || r_step == 3'd4) ? 3'd0 : r_step + 3'd1;
      end
   end

   always_comb begin
      w_act           = !i_reset && !r_halted && w_adv;
      w_t0            = w_act && r_step == 3'd0;
      w_t1            = w_act && r_step == 3'd1;
      w_t2            = w_act && r_step == 3'd2;
      w_t3            = w_act && r_step == 3'd3;
      w_t4            = w_act && r_step == 3'd4;
      w_alu           = w_op == 4'h2 || w_op == 4'h3;
      w_mem           = w_op == 4'h1 || w_alu || w_op == 4'h4;
      w_jmp           = w_op == 4'h6 || (w_op == 4'h7 && i_flag_carry) || (w_op == 4'h8 && i_flag_zero);
      o_pc_read_n     = !w_t0;
      o_pc_write_n    = !(w_t2 && w_jmp);
      o_pc_inc_n      = !w_t1;
      o_mar_write_n   = !(w_t0 || (w_t2 && w_mem));
      o_ram_read_n    = !(w_t1 || (w_t3 && (w_op == 4'h1 || w_alu)));
      o_ram_write_n   = !(w_t3 && w_op == 4'h4);
      o_ir_write_n    = !w_t1;
      o_ir_read_n     = !(w_t2 && (w_mem || w_op == 4'h5 || w_jmp));
      o_a_read_n      = !((w_t3 && w_op == 4'h4) || (w_t2 && w_op == 4'hE));
      o_a_write_n     = !((w_t3 && w_op == 4'h1) || (w_t4 && w_alu) || (w_t2 && w_op == 4'h5));
      o_b_write_n     = !(w_t3 && w_alu);
      o_alu_read_n    = !(w_t4 && w_alu);
      o_alu_sub       = (w_t3 || w_t4) && w_op == 4'h3;
      o_flags_write_n = !(w_t4 && w_alu);
      o_out_write_n   = !(w_t2 && w_op == 4'hE);
      o_halted        = r_halted && !i_reset;
      o_step          = i_reset ? 3'd0 : r_step;
   end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: checks SKIP_EMPTY_STEPS=1 and =0 instances against a table-driven microcode model.
module tb_control_sequencer;
   localparam logic [14:0] PCR = 15'h4000, PCW = 15'h2000, PCI = 15'h1000, MARW = 15'h0800,
                           RAMR = 15'h0400, RAMW = 15'h0200, IRW = 15'h0100, IRR = 15'h0080,
                           AR = 15'h0040, AW = 15'h0020, BW = 15'h0010, ALUR = 15'h0008,
                           SUB = 15'h0004, FW = 15'h0002, OUTW = 15'h0001;
   localparam logic [14:0] READS = PCR | RAMR | IRR | AR | ALUR;

   logic clk = 0, rst = 1, c = 0, z = 0;
   logic [7:0] instr = 0;
   logic [14:0] s1, s0;
   logic [2:0] st1, st0;
   logic h1, h0;
   int n_cmp = 0, n_bad = 0;
   int ms[2];
   bit mh[2];

   always #5 clk = ~clk;

   control_sequencer #(.SKIP_EMPTY_STEPS(1)) u1 (
      .i_clk(clk), .i_reset(rst), .i_instruction(instr), .i_flag_carry(c), .i_flag_zero(z),
`ifdef SEQ_SINGLE_STEP_EN
      .i_step_req(1'b1),
`endif
      .o_pc_read_n(s1[14]), .o_pc_write_n(s1[13]), .o_pc_inc_n(s1[12]), .o_mar_write_n(s1[11]),
      .o_ram_read_n(s1[10]), .o_ram_write_n(s1[9]), .o_ir_write_n(s1[8]), .o_ir_read_n(s1[7]),
      .o_a_read_n(s1[6]), .o_a_write_n(s1[5]), .o_b_write_n(s1[4]), .o_alu_read_n(s1[3]),
      .o_alu_sub(s1[2]), .o_flags_write_n(s1[1]), .o_out_write_n(s1[0]), .o_halted(h1), .o_step(st1));

   control_sequencer #(.SKIP_EMPTY_STEPS(0)) u0 (
      .i_clk(clk), .i_reset(rst), .i_instruction(instr), .i_flag_carry(c), .i_flag_zero(z),
`ifdef SEQ_SINGLE_STEP_EN
      .i_step_req(1'b1),
`endif
      .o_pc_read_n(s0[14]), .o_pc_write_n(s0[13]), .o_pc_inc_n(s0[12]), .o_mar_write_n(s0[11]),
      .o_ram_read_n(s0[10]), .o_ram_write_n(s0[9]), .o_ir_write_n(s0[8]), .o_ir_read_n(s0[7]),
      .o_a_read_n(s0[6]), .o_a_write_n(s0[5]), .o_b_write_n(s0[4]), .o_alu_read_n(s0[3]),
      .o_alu_sub(s0[2]), .o_flags_write_n(s0[1]), .o_out_write_n(s0[0]), .o_halted(h0), .o_step(st0));

   function automatic logic [14:0] mops(input logic [3:0] op, input int t, input logic fc, input logic fz);
      logic [14:0] m;
      m = (t == 0) ? (PCR | MARW) : (t == 1) ? (RAMR | IRW | PCI) : 15'h0;
      case (op)
         4'h1: m |= (t == 2) ? (IRR | MARW) : (t == 3) ? (RAMR | AW) : 15'h0;
         4'h2: m |= (t == 2) ? (IRR | MARW) : (t == 3) ? (RAMR | BW) : (t == 4) ? (ALUR | AW | FW) : 15'h0;
         4'h3: m |= (t == 2) ? (IRR | MARW) : (t == 3) ? (RAMR | BW | SUB) : (t == 4) ? (ALUR | AW | FW | SUB) : 15'h0;
         4'h4: m |= (t == 2) ? (IRR | MARW) : (t == 3) ? (AR | RAMW) : 15'h0;
         4'h5: m |= (t == 2) ? (IRR | AW) : 15'h0;
         4'h6: m |= (t == 2) ? (IRR | PCW) : 15'h0;
         4'h7: m |= (t == 2 && fc) ? (IRR | PCW) : 15'h0;
         4'h8: m |= (t == 2 && fz) ? (IRR | PCW) : 15'h0;
         4'hE: m |= (t == 2) ? (AR | OUTW) : 15'h0;
         default: ;
      endcase
      return m;
   endfunction

   function automatic int last_of(input logic [3:0] op);
      return (op == 4'h1 || op == 4'h4) ? 3 : (op == 4'h2 || op == 4'h3) ? 4 : 2;
   endfunction

   task automatic chk(input int k, input logic [14:0] s, input logic [2:0] st, input logic h);
      logic [14:0] obs, exp;
      obs = s ^ 15'h7FFB;
      exp = (rst || mh[k]) ? 15'h0 : mops(instr[7:4], ms[k], c, z);
      n_cmp++;
      assert (obs === exp) else begin n_bad++; $error("FAIL strobes skip=%0d t=%0t got=%h exp=%h", k, $time, obs, exp); end
      n_cmp++;
      assert (st === (rst ? 3'd0 : 3'(ms[k]))) else begin n_bad++; $error("FAIL step skip=%0d t=%0t got=%0d exp=%0d", k, $time, st, rst ? 0 : ms[k]); end
      n_cmp++;
      assert (h === (mh[k] && !rst)) else begin n_bad++; $error("FAIL halted skip=%0d t=%0t got=%b exp=%b", k, $time, h, mh[k] && !rst); end
      n_cmp++;
      assert ($countones(obs & READS) <= 1) else begin n_bad++; $error("FAIL one_read skip=%0d t=%0t got=%h exp=<=1 driver", k, $time, obs); end
      n_cmp++;
      assert (!(obs[13] && obs[12]) && !(obs[10] && obs[9])) else begin n_bad++; $error("FAIL exclusive skip=%0d t=%0t got=%h exp=no pc/ram conflict", k, $time, obs); end
   endtask

   task automatic upd(input int k);
      if (rst) begin ms[k] = 0; mh[k] = 0; end
      else if (!mh[k]) begin
         if (ms[k] == 2 && instr[7:4] == 4'hF) mh[k] = 1;
         else ms[k] = ((k == 1 && ms[k] == last_of(instr[7:4])) || ms[k] == 4) ? 0 : ms[k] + 1;
      end
   endtask

   task automatic go(input logic [7:0] i, input logic fc, input logic fz, input logic r, input int n);
      instr = i; c = fc; z = fz; rst = r;
      for (int j = 0; j < n; j++) begin
         #1;
         chk(1, s1, st1, h1);
         chk(0, s0, st0, h0);
         upd(1);
         upd(0);
         @(negedge clk);
      end
   endtask

   initial begin
      ms[0] = 0; ms[1] = 0; mh[0] = 0; mh[1] = 0;
      @(negedge clk);
      go(8'h00, 0, 0, 1, 1);
      go(8'h00, 0, 0, 0, 6);
      go(8'h00, 0, 0, 1, 1); go(8'h57, 0, 0, 0, 6);
      go(8'h00, 0, 0, 1, 1); go(8'h2A, 0, 0, 0, 6);
      go(8'h00, 0, 0, 1, 1); go(8'h3A, 1, 1, 0, 6);
      go(8'h00, 0, 0, 1, 1); go(8'h74, 0, 1, 0, 3);
      go(8'h00, 0, 0, 1, 1); go(8'h74, 1, 0, 0, 3);
      go(8'h00, 0, 0, 1, 1); go(8'h84, 1, 0, 0, 3);
      go(8'h00, 0, 0, 1, 1); go(8'h84, 0, 1, 0, 3);
      go(8'h00, 0, 0, 1, 1); go(8'h4C, 0, 0, 0, 5); go(8'hE0, 0, 0, 0, 5);
      go(8'h00, 0, 0, 1, 1); go(8'hF0, 0, 0, 0, 14);
      go(8'hF0, 0, 0, 1, 1); go(8'h10, 0, 0, 0, 5);
      go(8'h00, 0, 0, 1, 1); go(8'h2A, 0, 0, 0, 3); go(8'h2A, 0, 0, 1, 1); go(8'h2A, 0, 0, 0, 5);
      for (int j = 0; j < 500; j++)
         go(8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microcode sequencer for the 8-bit shared-bus CPU. It initiates every bus transfer by driving the active-low read/write/increment strobes that the bus responders (program counter, MAR, RAM, IR, A/B registers, ALU, output register) obey. It steps through a fixed fetch phase, then a per-opcode execute phase, and decodes the upper nibble of the instruction register.

Parameters:
SKIP_EMPTY_STEPS, 1, 1: return to T0 right after an opcode's last active step; 0: always run T0..T4.
OPCODE_WIDTH, 4, opcode = i_instruction[7:4]; operand = [3:0] (fixed 4, kept for documentation).

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  synchronous, active-high reset
i_instruction  input  8  instruction register contents
i_flag_carry  input  1  ALU carry flag (registered elsewhere)
i_flag_zero  input  1  ALU zero flag (registered elsewhere)
o_pc_read_n / o_pc_write_n / o_pc_inc_n  output  1 each  PC drive bus / load from bus / increment
o_mar_write_n  output  1  MAR load from bus
o_ram_read_n / o_ram_write_n  output  1 each  RAM drive bus / store from bus
o_ir_write_n / o_ir_read_n  output  1 each  IR load / drive operand nibble (zero-extended) on bus
o_a_read_n / o_a_write_n / o_b_write_n  output  1 each  A drive / A load / B load
o_alu_read_n  output  1  ALU result onto bus
o_alu_sub  output  1  1 = subtract
o_flags_write_n  output  1  latch carry/zero
o_out_write_n  output  1  output register load
o_halted  output  1  halted status
o_step  output  3  current micro-step 0..4

Behaviour:
- Registered state: step counter (0..4) and halted flag. All strobes are combinational decodes of step, opcode and flags; the responder acts on the next rising edge.
- Reset (sync): step=0, halted=0. While i_reset=1, every _n strobe=1, o_alu_sub=0, o_halted=0, o_step=0. Reset mid-instruction abandons it; the first cycle after release is T0.
- Fetch (all opcodes): T0 pc_read_n=0, mar_write_n=0. T1 ram_read_n=0, ir_write_n=0, pc_inc_n=0.
- Execute by opcode (unlisted strobes stay 1):
  - 0 NOP: none; last=T2.
  - 1 LDA: T2 ir_read,mar_write. T3 ram_read,a_write. Last=T3.
  - 2 ADD: T2 ir_read,mar_write. T3 ram_read,b_write. T4 alu_read,a_write,flags_write. Last=T4.
  - 3 SUB: same as ADD, with o_alu_sub=1 in T3 and T4.
  - 4 STA: T2 ir_read,mar_write. T3 a_read,ram_write. Last=T3.
  - 5 LDI: T2 ir_read,a_write.
  - 6 JMP: T2 ir_read,pc_write.
  - 7 JC: T2 ir_read,pc_write only if i_flag_carry=1.
  - 8 JZ: T2 ir_read,pc_write only if i_flag_zero=1.
  - E OUT: T2 a_read,out_write.
  - F HLT: T2 no strobes; the edge ending T2 sets halted=1.
  - 9..D: NOP.
  - Last step is T2 unless stated otherwise.
- Step advance: +1 per clock. After the last step the counter goes to 0 if SKIP_EMPTY_STEPS=1. If SKIP_EMPTY_STEPS=0 it runs idle through T4 and then wraps to 0.
- Halted: step frozen, every strobe=1, o_halted=1. Only reset exits.
- Invariants:
  - At most one *_read_n low per cycle.
  - pc_write_n and pc_inc_n never both low.
  - ram_read_n and ram_write_n never both low.
- Jump conditions sample the flags combinationally during T2.

Optional Feature:
SEQ_SINGLE_STEP_EN.
- Defined: adds input i_step_req (1 bit, after i_flag_zero). The step counter advances only on edges where i_step_req=1. Strobes are gated high except in cycles where i_step_req=1, so each responder acts exactly once per request. Halt and reset behave unchanged.
- Undefined: port absent; free-running advance every clock.

Test Plan:
1. Reset 1 cycle, release, hold i_instruction=8'h00. Required: step0 pc_read_n=0 and mar_write_n=0; step1 ram_read_n=0, ir_write_n=0, pc_inc_n=0; step2 no strobes; step returns to 0 (SKIP=1).
2. i_instruction=8'h57 (LDI). Required: T2 ir_read_n=0 and a_write_n=0, then o_step=0. With SKIP=0: o_step 3,4 show all strobes high, then 0.
3. 8'h2A (ADD). Required: T2 ir_read+mar_write; T3 ram_read+b_write; T4 alu_read+a_write+flags_write, alu_sub=0. Repeat with 8'h3A: alu_sub=1 in T3/T4.
4. 8'h74 (JC). Required: carry=0 gives T2 with all strobes high; carry=1 gives ir_read_n=0 and pc_write_n=0. Same checks for 8'h84 using zero flag.
5. 8'hF0 (HLT). Required: o_halted=1 from the cycle after T2; 10 further clocks with o_step frozen and all strobes high. 1-cycle reset gives o_halted=0 and o_step=0, and fetch resumes.
6. Random opcodes/flags, with reset pulsed mid-T3 of ADD. Required: invariants hold every cycle; T0 strobes appear on the cycle after reset release.
